// File: rtl/sync_port_pkg.sv
// Shared definitions for the SyncPort trigger/response blocks.
//   - Default counter widths for configuration/measurement and statistics.
//   - Responder FSM state encoding.
//   - Helper that maps a filter count of zero onto one.
package sync_port_pkg;

  localparam int unsigned DefCntW  = 32;
  localparam int unsigned DefStatW = 16;

  // Widest configuration value the helper accepts; callers extend and truncate.
  localparam int unsigned MaxCntW  = 64;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StPulse
  } respState_e;

  // A filter count of zero would never match a running count, so treat it as one.
  function automatic logic [MaxCntW-1:0] effFilterCnt(input logic [MaxCntW-1:0] cnt);
    return (cnt == '0) ? MaxCntW'(1) : cnt;
  endfunction

endpackage

// File: rtl/sync_in_filter.sv
// Trigger input qualifier: two-flop synchronizer, consecutive-cycle glitch filter with a
// one-cycle accept strobe, and active-width measurement of accepted episodes.
// Ports:
//   io_clk, io_rst_n     clock, asynchronous active-low reset
//   io_en                enable; low clears the filter and suppresses accepts
//   io_trigIn            raw asynchronous trigger
//   io_trigDefLev        idle level of io_trigIn
//   io_trigFilterCnt     consecutive active cycles required (0 behaves as 1)
//   io_accept            one-cycle strobe, one per active episode
//   io_trigWidth         active length of the last accepted episode, saturating
module sync_in_filter
  import sync_port_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             io_clk,
  input  logic             io_rst_n,
  input  logic             io_en,
  input  logic             io_trigIn,
  input  logic             io_trigDefLev,
  input  logic [CNT_W-1:0] io_trigFilterCnt,
  output logic             io_accept,
  output logic [CNT_W-1:0] io_trigWidth
);

  logic [1:0]       syncQ;
  logic             active;
  logic [CNT_W-1:0] cntQ, cntD, cntInc, target;
  logic             armedQ, armedD;
  logic             acceptQ, acceptD;
  logic             acceptedQ, acceptedD;
  logic [CNT_W-1:0] trigWidthQ, trigWidthD;

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      syncQ <= 2'b00;
    end else begin
      syncQ <= {syncQ[0], io_trigIn};
    end
  end

  assign active = syncQ[1] ^ io_trigDefLev;
  assign target = CNT_W'(effFilterCnt(MaxCntW'(io_trigFilterCnt)));
  // One counter serves both the filter and the width measurement; it saturates at all-ones.
  assign cntInc = (cntQ == '1) ? cntQ : cntQ + CNT_W'(1);

  always_comb begin
    cntD       = cntQ;
    armedD     = armedQ;
    acceptD    = 1'b0;
    acceptedD  = acceptedQ;
    trigWidthD = trigWidthQ;
    if (!io_en) begin
      // Disarm too, so a level still held when re-enabled cannot fire until it goes idle.
      cntD      = '0;
      armedD    = 1'b0;
      acceptedD = 1'b0;
    end else if (active) begin
      cntD = cntInc;
      if (armedQ && (cntInc == target)) begin
        acceptD   = 1'b1;
        armedD    = 1'b0;
        acceptedD = 1'b1;
      end
    end else begin
      cntD      = '0;
      armedD    = 1'b1;
      acceptedD = 1'b0;
      if (acceptedQ) begin
        trigWidthD = cntQ;
      end
    end
  end

  // Reset disarmed: the synchronizer comes up at 0, which looks active when the idle level is 1.
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      cntQ       <= '0;
      armedQ     <= 1'b0;
      acceptQ    <= 1'b0;
      acceptedQ  <= 1'b0;
      trigWidthQ <= '0;
    end else begin
      cntQ       <= cntD;
      armedQ     <= armedD;
      acceptQ    <= acceptD;
      acceptedQ  <= acceptedD;
      trigWidthQ <= trigWidthD;
    end
  end

  assign io_accept    = acceptQ;
  assign io_trigWidth = trigWidthQ;

endmodule

// File: rtl/sync_echo_responder.sv
// Far-end sync responder: qualifies a trigger, waits a programmable delay, then drives a
// feedback pulse of programmable width and level. Keeps accept/response/miss statistics.
// Ports:
//   io_clk, io_rst_n     clock, asynchronous active-low reset
//   io_en                enable; low aborts to idle and ignores accepts
//   io_trigIn            raw asynchronous trigger, idle level io_trigDefLev
//   io_trigFilterCnt     filter length in cycles (0 behaves as 1)
//   io_respDelay         cycles from accept to response start
//   io_respWidth         response length in cycles (0 = no pulse)
//   io_respDefLev        idle level of io_respOut
//   io_respOut           registered feedback pulse
//   io_busy              FSM not idle
//   io_trigWidth         active width of last accepted trigger
//   io_trigCounter       accepted triggers
//   io_respCounter       completed responses
//   io_missCounter       accepts dropped while busy
module sync_echo_responder
  import sync_port_pkg::*;
#(
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned STAT_W = DefStatW
) (
  input  logic              io_clk,
  input  logic              io_rst_n,
  input  logic              io_en,
  input  logic              io_trigIn,
  input  logic              io_trigDefLev,
  input  logic [CNT_W-1:0]  io_trigFilterCnt,
  input  logic [CNT_W-1:0]  io_respDelay,
  input  logic [CNT_W-1:0]  io_respWidth,
  input  logic              io_respDefLev,
  output logic              io_respOut,
  output logic              io_busy,
  output logic [CNT_W-1:0]  io_trigWidth,
  output logic [STAT_W-1:0] io_trigCounter,
  output logic [STAT_W-1:0] io_respCounter,
  output logic [STAT_W-1:0] io_missCounter
);

  logic              accept;
  respState_e        stateQ, stateD;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic [CNT_W-1:0]  widthQ, widthD;
  logic              respOutQ, respOutD;
  logic              trigEvent, missEvent, respEvent;
  logic [STAT_W-1:0] trigCntQ, respCntQ, missCntQ;

  sync_in_filter #(
    .CNT_W (CNT_W)
  ) u_filter (
    .io_clk           (io_clk),
    .io_rst_n         (io_rst_n),
    .io_en            (io_en),
    .io_trigIn        (io_trigIn),
    .io_trigDefLev    (io_trigDefLev),
    .io_trigFilterCnt (io_trigFilterCnt),
    .io_accept        (accept),
    .io_trigWidth     (io_trigWidth)
  );

  // State register
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      stateQ <= StIdle;
      cntQ   <= '0;
      widthQ <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      widthQ <= widthD;
    end
  end

  // Next state. Delay and width are captured at accept so later input changes
  // leave the burst in progress alone.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    widthD = widthQ;
    if (!io_en) begin
      stateD = StIdle;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (accept) begin
            widthD = io_respWidth;
            if (io_respDelay != '0) begin
              stateD = StDelay;
              cntD   = io_respDelay;
            end else if (io_respWidth != '0) begin
              stateD = StPulse;
              cntD   = io_respWidth;
            end
          end
        end
        StDelay: begin
          if (cntQ <= CNT_W'(1)) begin
            if (widthQ != '0) begin
              stateD = StPulse;
              cntD   = widthQ;
            end else begin
              stateD = StIdle;
            end
          end else begin
            cntD = cntQ - CNT_W'(1);
          end
        end
        StPulse: begin
          if (cntQ <= CNT_W'(1)) begin
            stateD = StIdle;
          end else begin
            cntD = cntQ - CNT_W'(1);
          end
        end
        default: stateD = StIdle;
      endcase
    end
  end

  // Outputs and event strobes. The response register tracks the next state so that
  // io_respOut is active exactly during the cycles the FSM sits in PULSE.
  always_comb begin
    respOutD  = (stateD == StPulse) ? ~io_respDefLev : io_respDefLev;
    trigEvent = io_en && accept && (stateQ == StIdle);
    missEvent = io_en && accept && (stateQ != StIdle);
    respEvent = io_en && (stateQ == StPulse) && (cntQ <= CNT_W'(1));
  end

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      respOutQ <= 1'b0;
      trigCntQ <= '0;
      respCntQ <= '0;
      missCntQ <= '0;
    end else begin
      respOutQ <= respOutD;
      if (trigEvent) trigCntQ <= trigCntQ + STAT_W'(1);
      if (respEvent) respCntQ <= respCntQ + STAT_W'(1);
      if (missEvent) missCntQ <= missCntQ + STAT_W'(1);
    end
  end

  assign io_respOut     = respOutQ;
  assign io_busy        = (stateQ != StIdle);
  assign io_trigCounter = trigCntQ;
  assign io_respCounter = respCntQ;
  assign io_missCounter = missCntQ;

endmodule

// File: tb/tb_sync_echo_responder.sv
`timescale 1ns/1ps
// Directed bench for sync_echo_responder. Cycle k means the interval just after clock edge k
// of an episode; trigger levels driven in cycle k are first sampled by edge k+1.
module tb_sync_echo_responder;

  localparam int unsigned CntW  = 32;
  localparam int unsigned StatW = 16;

  logic             clk = 1'b0;
  logic             rstN;
  logic             en;
  logic             trigIn;
  logic             trigDefLev;
  logic [CntW-1:0]  filterCnt;
  logic [CntW-1:0]  respDelay;
  logic [CntW-1:0]  respWidth;
  logic             respDefLev;
  logic             respOut;
  logic             busy;
  logic [CntW-1:0]  trigWidth;
  logic [StatW-1:0] trigCounter;
  logic [StatW-1:0] respCounter;
  logic [StatW-1:0] missCounter;

  int nChecks = 0;
  int nFails  = 0;

  logic respLog [0:1023];
  logic busyLog [0:1023];
  int   firstResp, lastResp, respCount, firstBusy;

  always #50 clk = ~clk;  // 10 MHz

  sync_echo_responder #(
    .CNT_W  (CntW),
    .STAT_W (StatW)
  ) dut (
    .io_clk           (clk),
    .io_rst_n         (rstN),
    .io_en            (en),
    .io_trigIn        (trigIn),
    .io_trigDefLev    (trigDefLev),
    .io_trigFilterCnt (filterCnt),
    .io_respDelay     (respDelay),
    .io_respWidth     (respWidth),
    .io_respDefLev    (respDefLev),
    .io_respOut       (respOut),
    .io_busy          (busy),
    .io_trigWidth     (trigWidth),
    .io_trigCounter   (trigCounter),
    .io_respCounter   (respCounter),
    .io_missCounter   (missCounter)
  );

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset with the idle levels applied, then releases and lets the filter arm.
  task automatic doReset(input logic lvT, input logic lvR, input bit chk);
    rstN       = 1'b0;
    en         = 1'b1;
    trigDefLev = lvT;
    trigIn     = lvT;
    respDefLev = lvR;
    tick();
    tick();
    if (chk) begin
      checkValue("rst_respOut", 64'(respOut), 64'd0);
      checkValue("rst_busy", 64'(busy), 64'd0);
      checkValue("rst_trigCnt", 64'(trigCounter), 64'd0);
      checkValue("rst_trigWidth", 64'(trigWidth), 64'd0);
    end
    rstN = 1'b1;
    tick();
    tick();
  endtask

  // Drives up to two trigger windows and an optional enable drop, logging outputs per cycle.
  task automatic runEpisode(input int nCyc, input int s1, input int l1, input int s2,
                            input int l2, input int enOff);
    respLog[0] = respOut;
    busyLog[0] = busy;
    for (int c = 0; c < nCyc; c++) begin
      trigIn = trigDefLev ^ ((c >= s1 && c < s1 + l1) || (c >= s2 && c < s2 + l2));
      en     = !(enOff >= 0 && c >= enOff);
      tick();
      respLog[c+1] = respOut;
      busyLog[c+1] = busy;
    end
    trigIn    = trigDefLev;
    en        = 1'b1;
    firstResp = -1;
    lastResp  = -1;
    firstBusy = -1;
    respCount = 0;
    for (int c = 1; c <= nCyc; c++) begin
      if (respLog[c] != respDefLev) begin
        if (firstResp < 0) firstResp = c;
        lastResp = c;
        respCount++;
      end
      if (busyLog[c] && firstBusy < 0) firstBusy = c;
    end
  endtask

  initial begin
    filterCnt = 32'd300;
    respDelay = 32'd150;
    respWidth = 32'd200;

    // 1: long trigger, full delay + pulse
    doReset(1'b0, 1'b0, 1'b1);
    runEpisode(700, 0, 450, 0, 0, -1);
    checkValue("t1_firstBusy", 64'(firstBusy), 64'd303);
    checkValue("t1_firstResp", 64'(firstResp), 64'd453);
    checkValue("t1_lastResp", 64'(lastResp), 64'd652);
    checkValue("t1_respCount", 64'(respCount), 64'd200);
    checkValue("t1_trigCnt", 64'(trigCounter), 64'd1);
    checkValue("t1_respCnt", 64'(respCounter), 64'd1);
    checkValue("t1_missCnt", 64'(missCounter), 64'd0);
    checkValue("t1_trigWidth", 64'(trigWidth), 64'd450);
    checkValue("t1_busyEnd", 64'(busy), 64'd0);

    // 2: trigger shorter than the filter, nothing changes
    runEpisode(200, 0, 100, 0, 0, -1);
    checkValue("t2_respCount", 64'(respCount), 64'd0);
    checkValue("t2_firstBusy", 64'(firstBusy), 64'hFFFF_FFFF_FFFF_FFFF);
    checkValue("t2_trigCnt", 64'(trigCounter), 64'd1);
    checkValue("t2_respCnt", 64'(respCounter), 64'd1);
    checkValue("t2_missCnt", 64'(missCounter), 64'd0);
    checkValue("t2_trigWidth", 64'(trigWidth), 64'd450);

    // 3a: minimal latency, single-cycle pulse
    filterCnt = 32'd1;
    respDelay = 32'd0;
    respWidth = 32'd1;
    doReset(1'b0, 1'b0, 1'b0);
    runEpisode(30, 0, 5, 0, 0, -1);
    checkValue("t3a_firstResp", 64'(firstResp), 64'd4);
    checkValue("t3a_respCount", 64'(respCount), 64'd1);
    checkValue("t3a_respCnt", 64'(respCounter), 64'd1);
    checkValue("t3a_trigWidth", 64'(trigWidth), 64'd5);

    // 3b: zero width, no pulse
    respWidth = 32'd0;
    doReset(1'b0, 1'b0, 1'b0);
    runEpisode(30, 0, 5, 0, 0, -1);
    checkValue("t3b_respCount", 64'(respCount), 64'd0);
    checkValue("t3b_firstBusy", 64'(firstBusy), 64'hFFFF_FFFF_FFFF_FFFF);
    checkValue("t3b_trigCnt", 64'(trigCounter), 64'd1);
    checkValue("t3b_respCnt", 64'(respCounter), 64'd0);

    // 4: second accept during DELAY is dropped
    filterCnt = 32'd2;
    respDelay = 32'd50;
    respWidth = 32'd10;
    doReset(1'b0, 1'b0, 1'b0);
    runEpisode(100, 0, 5, 10, 5, -1);
    checkValue("t4_firstResp", 64'(firstResp), 64'd55);
    checkValue("t4_respCount", 64'(respCount), 64'd10);
    checkValue("t4_trigCnt", 64'(trigCounter), 64'd1);
    checkValue("t4_missCnt", 64'(missCounter), 64'd1);
    checkValue("t4_respCnt", 64'(respCounter), 64'd1);
    checkValue("t4_trigWidth", 64'(trigWidth), 64'd5);

    // 5: inverted levels
    filterCnt = 32'd3;
    respDelay = 32'd5;
    respWidth = 32'd7;
    doReset(1'b1, 1'b1, 1'b1);
    checkValue("t5_idleAfterRst", 64'(respOut), 64'd1);
    runEpisode(40, 0, 6, 0, 0, -1);
    checkValue("t5_idleEarly", 64'(respLog[1]), 64'd1);
    checkValue("t5_firstResp", 64'(firstResp), 64'd11);
    checkValue("t5_lastResp", 64'(lastResp), 64'd17);
    checkValue("t5_respCount", 64'(respCount), 64'd7);
    checkValue("t5_trigWidth", 64'(trigWidth), 64'd6);

    // 6a: enable dropped mid-PULSE
    filterCnt = 32'd1;
    respDelay = 32'd3;
    respWidth = 32'd20;
    doReset(1'b0, 1'b0, 1'b0);
    runEpisode(40, 0, 3, 0, 0, 10);
    checkValue("t6a_respAt10", 64'(respLog[10]), 64'd1);
    checkValue("t6a_respAt11", 64'(respLog[11]), 64'd0);
    checkValue("t6a_busyAt11", 64'(busyLog[11]), 64'd0);
    checkValue("t6a_respCount", 64'(respCount), 64'd4);
    checkValue("t6a_respCnt", 64'(respCounter), 64'd0);
    checkValue("t6a_trigCnt", 64'(trigCounter), 64'd1);
    checkValue("t6a_missCnt", 64'(missCounter), 64'd0);

    // 6b: asynchronous reset mid-DELAY
    respDelay = 32'd30;
    respWidth = 32'd5;
    doReset(1'b0, 1'b1, 1'b0);
    runEpisode(12, 0, 3, 0, 0, -1);
    checkValue("t6b_busyPre", 64'(busy), 64'd1);
    checkValue("t6b_respPre", 64'(respOut), 64'd1);
    checkValue("t6b_widthPre", 64'(trigWidth), 64'd3);
    checkValue("t6b_trigCntPre", 64'(trigCounter), 64'd1);
    #20;
    rstN = 1'b0;
    #1;
    checkValue("t6b_busyRst", 64'(busy), 64'd0);
    checkValue("t6b_respRst", 64'(respOut), 64'd0);
    checkValue("t6b_widthRst", 64'(trigWidth), 64'd0);
    checkValue("t6b_trigCntRst", 64'(trigCounter), 64'd0);
    tick();
    rstN = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
